// File: rtl/mux_nx1_arb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mux_nx1_arb : N-input registered mux with round-robin/fixed arbiter    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module mux_nx1_arb #(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] i,
  input  logic [N-1:0]   i_valid,
  output logic [N-1:0]   i_ready,
  input  logic           mode,
  output logic [W-1:0]   out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_sel
);

  localparam logic [SW-1:0] C_PTR_RST = SW'(N - 1);

  logic [SW-1:0] r_ptr;
  logic          w_load;
  logic          w_any;
  logic          w_xfer;
  logic [N-1:0]  w_hi;
  logic [SW-1:0] w_rr_idx;
  logic [SW-1:0] w_fp_idx;
  logic [SW-1:0] w_grant;
  logic [W-1:0]  w_grant_data;

  function automatic logic [SW-1:0] f_lowest(input logic [N-1:0] v);
    logic [SW-1:0] idx;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (v[k]) idx = SW'(k);
    end
    return idx;
  endfunction

  assign w_any  = |i_valid;
  assign w_load = !out_valid | out_ready;
  assign w_xfer = w_load & w_any;

  // Round-robin: lowest requester above the last winner, else wrap to the lowest overall.
  always_comb begin
    w_hi = '0;
    for (int k = 0; k < N; k++) begin
      w_hi[k] = i_valid[k] && (k > int'(r_ptr));
    end
  end

  assign w_fp_idx = f_lowest(i_valid);
  assign w_rr_idx = (|w_hi) ? f_lowest(w_hi) : w_fp_idx;
  assign w_grant  = mode ? w_fp_idx : w_rr_idx;

  always_comb begin
    i_ready = '0;
    for (int k = 0; k < N; k++) begin
      i_ready[k] = w_xfer && (int'(w_grant) == k);
    end
  end

  always_comb begin
    w_grant_data = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(w_grant) == k) w_grant_data = i[k*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
      r_ptr     <= C_PTR_RST;
    end else if (w_xfer) begin
      out       <= w_grant_data;
      out_sel   <= w_grant;
      out_valid <= 1'b1;
      r_ptr     <= w_grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_nx1_arb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mux_nx1_arb : table-driven bench with scoreboard for mux_nx1_arb    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_mux_nx1_arb;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] i;
  logic [N-1:0]   i_valid;
  logic [N-1:0]   i_ready;
  logic           mode;
  logic [W-1:0]   out;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_sel;

  always #5 clk = ~clk;

  mux_nx1_arb #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i         (i),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .mode      (mode),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  typedef struct packed {
    logic       pre_rst;
    logic [7:0] valid;
    logic       mode;
    logic       ordy;
    logic [7:0] d0;
    logic [7:0] exp_rdy;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] sel;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  logic        m_ov;
  logic [7:0]  m_out;
  logic [2:0]  m_sel;

  function automatic vec_t mk(input logic [7:0] v, input logic m, input logic r,
                              input logic [7:0] d0, input logic [7:0] e, input logic pr);
    vec_t x;
    x.pre_rst = pr;
    x.valid   = v;
    x.mode    = m;
    x.ordy    = r;
    x.d0      = d0;
    x.exp_rdy = e;
    return x;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h, expected %0h", nm, row, act, exp);
    end
  endtask

  // Registered outputs are checked against the bench model one step after each edge.
  task automatic check_regs(input int row);
    chk("out_valid", row, 32'(out_valid), 32'(m_ov));
    chk("out", row, 32'(out), 32'(m_out));
    chk("out_sel", row, 32'(out_sel), 32'(m_sel));
  endtask

  task automatic run_row(input vec_t r, input int row);
    logic       xfer;
    logic       ov_n;
    int         idx;
    logic [7:0] dch;
    exp_t       e;
    i_valid   = r.valid;
    mode      = r.mode;
    out_ready = r.ordy;
    for (int k = 0; k < N; k++) begin
      i[k*W +: W] = (k == 0) ? r.d0 : 8'(8'h10 + k);
    end
    #2;
    chk("i_ready", row, 32'(i_ready), 32'(r.exp_rdy));
    xfer = |(r.exp_rdy & r.valid);
    idx  = 0;
    for (int k = 0; k < N; k++) begin
      if (r.exp_rdy[k]) idx = k;
    end
    if (xfer) begin
      dch    = (idx == 0) ? r.d0 : 8'(8'h10 + idx);
      e.data = dch;
      e.sel  = 3'(idx);
      sbq.push_back(e);
      ov_n = 1'b1;
    end else if (r.ordy) begin
      ov_n = 1'b0;
    end else begin
      ov_n = m_ov;
    end
    @(posedge clk);
    #1;
    m_ov = ov_n;
    if (xfer) begin
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard row %0d: got empty queue, expected entry", row);
      end else begin
        e     = sbq.pop_front();
        m_out = e.data;
        m_sel = e.sel;
      end
    end
    check_regs(row);
  endtask

  task automatic do_async_reset(input int row);
    #2;
    rst_n   = 1'b0;
    i_valid = '0;
    #1;
    m_ov  = 1'b0;
    m_out = '0;
    m_sel = '0;
    sbq.delete();
    check_regs(row);
    @(posedge clk);
    #1;
    check_regs(row);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rr_seq [10];
    rst_n     = 1'b0;
    i_valid   = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    i         = '0;
    m_ov      = 1'b0;
    m_out     = '0;
    m_sel     = '0;

    repeat (2) @(posedge clk);
    #1;
    check_regs(-1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // first grant after reset, then park the pointer on channel 7
    tbl.push_back(mk(8'h01, 1'b0, 1'b1, 8'hA5, 8'h01, 1'b0));
    tbl.push_back(mk(8'h80, 1'b0, 1'b1, 8'h10, 8'h80, 1'b0));
    // all channels requesting: rotation 0..7,0,1
    rr_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    for (int k = 0; k < 10; k++) tbl.push_back(mk(8'hFF, 1'b0, 1'b1, 8'h10, rr_seq[k], 1'b0));
    // retire pending channels one by one as each is accepted
    tbl.push_back(mk(8'hFD, 1'b0, 1'b1, 8'h10, 8'h04, 1'b0));
    tbl.push_back(mk(8'hF9, 1'b0, 1'b1, 8'h10, 8'h08, 1'b0));
    tbl.push_back(mk(8'hF1, 1'b0, 1'b1, 8'h10, 8'h10, 1'b0));
    tbl.push_back(mk(8'hE1, 1'b0, 1'b1, 8'h10, 8'h20, 1'b0));
    tbl.push_back(mk(8'hC1, 1'b0, 1'b1, 8'h10, 8'h40, 1'b0));
    tbl.push_back(mk(8'h81, 1'b0, 1'b1, 8'h10, 8'h80, 1'b0));
    tbl.push_back(mk(8'h01, 1'b0, 1'b1, 8'h10, 8'h01, 1'b0));
    // fixed priority starves channel 3, then round-robin alternates 3,2,3
    for (int k = 0; k < 3; k++) tbl.push_back(mk(8'h0C, 1'b1, 1'b1, 8'h10, 8'h04, 1'b0));
    tbl.push_back(mk(8'h0C, 1'b0, 1'b1, 8'h10, 8'h08, 1'b0));
    tbl.push_back(mk(8'h0C, 1'b0, 1'b1, 8'h10, 8'h04, 1'b0));
    tbl.push_back(mk(8'h0C, 1'b0, 1'b1, 8'h10, 8'h08, 1'b0));
    tbl.push_back(mk(8'h04, 1'b0, 1'b1, 8'h10, 8'h04, 1'b0));
    // backpressure for 5 cycles, then channel 7 accepted
    for (int k = 0; k < 5; k++) tbl.push_back(mk(8'h80, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0));
    tbl.push_back(mk(8'h80, 1'b0, 1'b1, 8'h10, 8'h80, 1'b0));
    // drain to idle; pointer must still sit on 7
    tbl.push_back(mk(8'h00, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0));
    tbl.push_back(mk(8'hFF, 1'b0, 1'b1, 8'h10, 8'h01, 1'b0));
    tbl.push_back(mk(8'hFE, 1'b0, 1'b1, 8'h10, 8'h02, 1'b0));
    tbl.push_back(mk(8'hFC, 1'b0, 1'b1, 8'h10, 8'h04, 1'b0));
    // async reset while a beat is held; search restarts at channel 0
    tbl.push_back(mk(8'h81, 1'b0, 1'b1, 8'h10, 8'h01, 1'b1));
    tbl.push_back(mk(8'h80, 1'b0, 1'b1, 8'h10, 8'h80, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0));

    for (int n = 0; n < tbl.size(); n++) begin
      if (tbl[n].pre_rst) do_async_reset(n);
      run_row(tbl[n], n);
    end

    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sbq.size());
    end
    checks++;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
